// File: rtl/snake_px_responder.sv
// Avalon-MM pixel-write slave: decodes (x,y), posts writes through a small FIFO into a linear frame buffer.
// Optional coherent pixel readback is built when SNAKE_PX_READBACK_EN is defined.
module snake_px_responder #(
    parameter int X_LSB      = 1,
    parameter int Y_LSB      = 10,
    parameter int NUM_X      = 320,
    parameter int NUM_Y      = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] avs_address,
    input  logic        avs_write,
    input  logic [15:0] avs_writedata,
    input  logic        avs_read,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [16:0] fb_addr,
    output logic        fb_we,
    output logic [15:0] fb_wdata,
    output logic        fb_re,
    input  logic [15:0] fb_rdata,
    input  logic        fb_ready,
    output logic [15:0] oob_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic        px_in_range;
    logic [16:0] px_lin;

    assign px_x        = avs_address[X_LSB +: 9];
    assign px_y        = avs_address[Y_LSB +: 8];
    assign px_in_range = (32'(px_x) < NUM_X) && (32'(px_y) < NUM_Y);
    assign px_lin      = 17'({px_y, 8'b0}) + 17'({px_y, 6'b0}) + 17'(px_x);

    logic [16:0] addr_mem_q [FIFO_DEPTH];
    logic [15:0] data_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [15:0]   oob_q;

    logic fifo_full, fifo_empty;
    logic wr_accept, push, pop, oob_hit;
    logic rd_block, rd_wait;

    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign wr_accept  = avs_write & ~fifo_full;
    assign push       = wr_accept & px_in_range;
    assign oob_hit    = wr_accept & ~px_in_range;
    assign pop        = ~fifo_empty & fb_ready & ~rd_block;

    assign fb_we           = pop;
    assign fb_wdata        = pop ? data_mem_q[rd_ptr_q] : '0;
    assign oob_count       = oob_q;
    assign avs_waitrequest = (avs_write & fifo_full) | rd_wait;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            oob_q    <= '0;
        end else begin
            if (push) begin
                addr_mem_q[wr_ptr_q] <= px_lin;
                data_mem_q[wr_ptr_q] <= avs_writedata;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (oob_hit && (oob_q != '1)) begin
                oob_q <= oob_q + 16'd1;
            end
        end
    end

`ifdef SNAKE_PX_READBACK_EN
    typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_ISSUE, RD_WAIT, RD_DONE} rd_state_e;

    rd_state_e   state_q, state_d;
    logic [16:0] rd_addr_q, rd_addr_d;
    logic        rd_oob_q, rd_oob_d;
    logic [15:0] rdata_q, rdata_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            rd_oob_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            rd_oob_q  <= rd_oob_d;
            rdata_q   <= rdata_d;
        end
    end

    // A concurrent write wins the cycle and the read FSM holds; a dropped read aborts to IDLE.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_oob_d  = rd_oob_q;
        rdata_d   = rdata_q;
        fb_re     = 1'b0;
        if (avs_read && !avs_write) begin
            case (state_q)
                IDLE: begin
                    state_d   = RD_DRAIN;
                    rd_addr_d = px_lin;
                    rd_oob_d  = ~px_in_range;
                end
                RD_DRAIN: begin
                    if (fifo_empty) begin
                        if (rd_oob_q) begin
                            rdata_d = '0;
                            state_d = RD_DONE;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    fb_re = fb_ready;
                    if (fb_ready) state_d = RD_WAIT;
                end
                RD_WAIT: begin
                    rdata_d = fb_rdata;
                    state_d = RD_DONE;
                end
                RD_DONE:  state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end else if (!avs_read) begin
            state_d = IDLE;
        end
    end

    assign rd_block     = (state_q == RD_ISSUE);
    assign rd_wait      = avs_read & ~avs_write & (state_q != RD_DONE);
    assign avs_readdata = (state_q == RD_DONE) ? rdata_q : '0;
    assign fb_addr      = pop ? addr_mem_q[rd_ptr_q] : (fb_re ? rd_addr_q : '0);
`else
    logic unused_inputs;
    assign unused_inputs = ^{avs_read, fb_rdata};
    assign rd_block      = 1'b0;
    assign rd_wait       = 1'b0;
    assign fb_re         = 1'b0;
    assign avs_readdata  = '0;
    assign fb_addr       = pop ? addr_mem_q[rd_ptr_q] : '0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^avs_address;

    rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n) !(avs_read && avs_write));

endmodule

// File: tb/tb_snake_px_responder.sv
// Self-checking bench for snake_px_responder: randomized traffic against a queue-based reference model.
module tb_snake_px_responder;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] avs_address = '0;
    logic        avs_write = 1'b0;
    logic [15:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [16:0] fb_addr;
    logic        fb_we;
    logic [15:0] fb_wdata;
    logic        fb_re;
    logic [15:0] fb_rdata = '0;
    logic        fb_ready = 1'b0;
    logic [15:0] oob_count;

    snake_px_responder #(.X_LSB(1), .Y_LSB(10), .NUM_X(320), .NUM_Y(240), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata),
        .fb_re(fb_re), .fb_rdata(fb_rdata), .fb_ready(fb_ready), .oob_count(oob_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [16:0] a; logic [15:0] d; } ent_t;
    ent_t        q[$];
    int          checks = 0, errors = 0;
    int          oob_ref = 0, we_cnt = 0, re_cnt = 0;
    logic [16:0] last_we_addr = '0;
    logic [15:0] last_we_data = '0;
    logic [15:0] ref_pix [int];
    logic [15:0] fbmem [int];
    bit          rnd_ready = 0;

    function automatic logic [31:0] mk_addr(int x, int y);
        logic [31:0] junk = $urandom;
        return (junk & 32'hFFFC_0001) | (32'(x) << 1) | (32'(y) << 10);
    endfunction

    // Reference model and protocol monitor, evaluated once per cycle away from the active edge.
    always @(negedge clk) begin : mon
        ent_t e;
        int   x, y;
        bit   exp_wr;
        if (!reset_n) begin
            q.delete();
            oob_ref = 0;
            checks++;
            if (fb_we !== 1'b0 || fb_re !== 1'b0 || oob_count !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold: fb_we=%b fb_re=%b oob=%h required 0/0/0", fb_we, fb_re, oob_count);
            end
        end else begin
            checks++;
            if (oob_count !== 16'(oob_ref)) begin
                errors++;
                $display("FAIL oob_count: got %h required %h", oob_count, 16'(oob_ref));
            end
            if (!avs_read) begin
                exp_wr = avs_write && (q.size() == DEPTH);
                checks++;
                if (avs_waitrequest !== exp_wr) begin
                    errors++;
                    $display("FAIL waitrequest: got %b required %b (level %0d)", avs_waitrequest, exp_wr, q.size());
                end
            end
            if (fb_we === 1'b1) begin
                checks++;
                if (fb_ready !== 1'b1 || q.size() == 0) begin
                    errors++;
                    $display("FAIL we_unexpected: fb_we=1 with fb_ready=%b level=%0d", fb_ready, q.size());
                end else begin
                    e = q.pop_front();
                    if (fb_addr !== e.a || fb_wdata !== e.d) begin
                        errors++;
                        $display("FAIL we_order: got addr=%0d data=%h required addr=%0d data=%h", fb_addr, fb_wdata, e.a, e.d);
                    end
                end
                we_cnt++;
                last_we_addr = fb_addr;
                last_we_data = fb_wdata;
            end
            if (fb_re === 1'b1) begin
                checks++;
                if (fb_ready !== 1'b1 || q.size() != 0 || fb_we === 1'b1) begin
                    errors++;
                    $display("FAIL re_early: fb_re=1 with fb_ready=%b level=%0d required ready and empty", fb_ready, q.size());
                end
                re_cnt++;
            end
            if (avs_write && !avs_waitrequest) begin
                x = int'((avs_address >> 1) & 32'h1FF);
                y = int'((avs_address >> 10) & 32'hFF);
                if (x < 320 && y < 240) begin
                    e.a = 17'(y * 320 + x);
                    e.d = avs_writedata;
                    q.push_back(e);
                    ref_pix[y * 320 + x] = avs_writedata;
                end else if (oob_ref < 65535) begin
                    oob_ref++;
                end
            end
        end
    end

    // Frame-buffer stand-in: read data valid exactly one cycle after fb_re, junk otherwise.
    always @(posedge clk) begin
        if (fb_we && fb_ready) fbmem[int'(fb_addr)] = fb_wdata;
        if (fb_re && fb_ready) fb_rdata <= fbmem.exists(int'(fb_addr)) ? fbmem[int'(fb_addr)] : 16'hDEAD;
        else                   fb_rdata <= 16'($urandom);
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) fb_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wr(int x, int y, logic [15:0] d);
        int n = 0;
        avs_address   = mk_addr(x, y);
        avs_writedata = d;
        avs_write     = 1'b1;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL wr_timeout: waitrequest=%b after %0d cycles required 0", avs_waitrequest, n);
                break;
            end
        end
        step();
        avs_write = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        rnd_ready = 0;
        fb_ready  = 1'b1;
        forever begin
            @(negedge clk); #1;
            if (q.size() == 0) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL drain_timeout: level=%0d required 0", q.size());
                break;
            end
        end
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (fb_we !== 0 || fb_re !== 0 || fb_addr !== 0 || fb_wdata !== 0 || avs_readdata !== 0 ||
            avs_waitrequest !== 0 || oob_count !== 0) begin
            errors++;
            $display("FAIL reset_values: we=%b re=%b addr=%h wdata=%h rdata=%h wait=%b oob=%h required all 0",
                     fb_we, fb_re, fb_addr, fb_wdata, avs_readdata, avs_waitrequest, oob_count);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int c = we_cnt;
        fb_ready = 1'b1;
        wr(5, 2, 16'hF800);
        repeat (3) step();
        checks++;
        if (we_cnt != c + 1 || last_we_addr !== 17'd645 || last_we_data !== 16'hF800) begin
            errors++;
            $display("FAIL single_write: count=%0d addr=%0d data=%h required 1/645/F800", we_cnt - c, last_we_addr, last_we_data);
        end
    endtask

    task automatic fill_then_stall(logic [15:0] base);
        int n = 0;
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(10 + i, 7, base + 16'(i));
        avs_address   = mk_addr(20, 7);
        avs_writedata = base + 16'd4;
        avs_write     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (avs_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL full_stall: waitrequest=%b required 1", avs_waitrequest);
            end
        end
        step();
        fb_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL stall_release: waitrequest=%b required 0", avs_waitrequest);
                break;
            end
        end
        step();
        avs_write = 1'b0;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int c = we_cnt;
        fill_then_stall(16'h1230);
        checks++;
        if (we_cnt != c + 5 || last_we_data !== 16'h1234) begin
            errors++;
            $display("FAIL back_to_back: count=%0d last=%h required 5/1234", we_cnt - c, last_we_data);
        end
    endtask

    task automatic test_oob();
        int c = we_cnt;
        int base = oob_ref;
        wr(320, 0, 16'hAAAA);
        wr(0, 240, 16'h5555);
        repeat (3) step();
        checks++;
        if (oob_count !== 16'(base + 2) || we_cnt != c) begin
            errors++;
            $display("FAIL oob_drop: oob=%0d fb_we=%0d required %0d/0", oob_count, we_cnt - c, base + 2);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(i, 1, 16'hC000 + 16'(i));
        wr(330, 3, 16'h0);
        reset_n = 1'b0;
        c = we_cnt;
        repeat (2) step();
        fb_ready = 1'b1;
        step();
        reset_n = 1'b1;
        repeat (8) step();
        checks++;
        if (we_cnt != c || oob_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid: fb_we=%0d oob=%h required 0/0", we_cnt - c, oob_count);
        end
        fill_then_stall(16'h7700);
    endtask

    task automatic test_random();
        rnd_ready = 1;
        for (int i = 0; i < 60; i++)
            wr($urandom_range(0, 335), $urandom_range(0, 250), 16'($urandom));
        wait_drain();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: level=%0d required 0", q.size());
        end
    endtask

    task automatic test_oob_saturate();
        test_reset();
        avs_write = 1'b1;
        repeat (65534) begin
            avs_address = mk_addr($urandom_range(320, 511), $urandom_range(0, 255));
            step();
        end
        avs_write = 1'b0;
        step();
        checks++;
        if (oob_count !== 16'hFFFE) begin
            errors++;
            $display("FAIL oob_preload: got %h required FFFE", oob_count);
        end
        for (int i = 0; i < 3; i++) wr(100, 240 + i, 16'h0);
        step();
        checks++;
        if (oob_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL oob_saturate: got %h required FFFF", oob_count);
        end
    endtask

`ifdef SNAKE_PX_READBACK_EN
    task automatic rd(int x, int y, int pre_stall, output logic [15:0] data);
        int n = 0;
        avs_address = mk_addr(x, y);
        avs_read    = 1'b1;
        repeat (pre_stall) begin
            @(negedge clk);
            checks++;
            if (fb_re !== 1'b0 || avs_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL read_hold: fb_re=%b wait=%b required 0/1", fb_re, avs_waitrequest);
            end
        end
        if (pre_stall > 0) begin
            step();
            fb_ready = 1'b1;
        end
        forever begin
            @(negedge clk);
            if (!avs_waitrequest) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL read_timeout: waitrequest=%b required 0", avs_waitrequest);
                break;
            end
        end
        data = avs_readdata;
        step();
        avs_read = 1'b0;
        step();
    endtask

    task automatic test_read();
        int c, r;
        logic [15:0] d;
        fb_ready = 1'b1;
        wr(5, 2, 16'h07E0);
        wait_drain();
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(40 + i, 9, 16'($urandom));
        c = we_cnt;
        r = re_cnt;
        rd(5, 2, 4, d);
        checks++;
        if (d !== ref_pix[645] || we_cnt != c + 3 || re_cnt != r + 1) begin
            errors++;
            $display("FAIL read_coherent: data=%h we=%0d re=%0d required %h/3/1", d, we_cnt - c, re_cnt - r, ref_pix[645]);
        end
    endtask

    task automatic test_read_random();
        int keys[$];
        int k, r;
        logic [15:0] d;
        foreach (ref_pix[a]) keys.push_back(a);
        rnd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            k = keys[$urandom_range(0, keys.size() - 1)];
            rd(k % 320, k / 320, 0, d);
            checks++;
            if (d !== ref_pix[k]) begin
                errors++;
                $display("FAIL read_random: addr=%0d got %h required %h", k, d, ref_pix[k]);
            end
        end
        r = re_cnt;
        rd(321, 5, 0, d);
        checks++;
        if (d !== 16'h0000 || re_cnt != r) begin
            errors++;
            $display("FAIL read_oob: data=%h fb_re=%0d required 0000/0", d, re_cnt - r);
        end
        rnd_ready = 0;
    endtask

    task automatic test_read_abort();
        logic [15:0] d;
        fb_ready    = 1'b1;
        avs_address = mk_addr(5, 2);
        avs_read    = 1'b1;
        repeat (3) step();
        avs_read = 1'b0;
        repeat (3) step();
        wr(5, 2, 16'hBEEF);
        wait_drain();
        rd(5, 2, 0, d);
        checks++;
        if (d !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_abort: data=%h required BEEF", d);
        end
    endtask
`else
    task automatic test_read_ignored();
        int r = re_cnt;
        avs_address = mk_addr(5, 2);
        avs_read    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (avs_waitrequest !== 1'b0 || avs_readdata !== 16'h0 || fb_re !== 1'b0) begin
                errors++;
                $display("FAIL read_ignored: wait=%b data=%h fb_re=%b required 0/0000/0", avs_waitrequest, avs_readdata, fb_re);
            end
        end
        step();
        avs_read = 1'b0;
        step();
        checks++;
        if (re_cnt != r) begin
            errors++;
            $display("FAIL read_no_fb_re: fb_re count=%0d required 0", re_cnt - r);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_oob();
        test_reset_mid();
        test_random();
`ifdef SNAKE_PX_READBACK_EN
        test_read();
        test_read_random();
        test_read_abort();
`else
        test_read_ignored();
`endif
        test_oob_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
